ahb_param_decoder: RTL and testbench

AHB_PARAM_DECODER -- requirements
Module: ahb_param_decoder

---
 rtl/ahb_param_decoder.sv | 158 +++++++++++++++
 tb/tb_ahb_param_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_param_decoder.sv
// Parameterised AHB address decoder with per-port output mux and default slave.
// Optional macro AHB_DEC_ERRCNT_EN adds a saturating default-slave error counter.
module ahb_param_decoder #(
    parameter int                        NUM_PORTS   = 4,
    parameter logic [NUM_PORTS*22-1:0]   ADDR_BASE   = {22'h000300, 22'h000200,
                                                        22'h000100, 22'h000000},
    parameter logic [NUM_PORTS*22-1:0]   ADDR_LIMIT  = {22'h0003ff, 22'h0002ff,
                                                        22'h0001ff, 22'h0000ff},
    parameter int                        REMAP_PORT  = 1,
    parameter logic [21:0]               REMAP_LIMIT = 22'h00001f,
    parameter int                        DATA_W      = 32,
    parameter int                        USER_W      = 32
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          remapping_dec,
    input  logic                          HREADYS,
    input  logic                          sel_dec,
    input  logic [21:0]                   decode_addr_dec,
    input  logic [1:0]                    trans_dec,
    input  logic [NUM_PORTS-1:0]          active_in,
    input  logic [NUM_PORTS-1:0]          readyout_in,
    input  logic [2*NUM_PORTS-1:0]        resp_in,
    input  logic [DATA_W*NUM_PORTS-1:0]   rdata_in,
    input  logic [USER_W*NUM_PORTS-1:0]   ruser_in,
    output logic [NUM_PORTS-1:0]          sel_out,
    output logic                          active_dec,
    output logic                          HREADYOUTS,
    output logic [1:0]                    HRESPS,
    output logic [DATA_W-1:0]             HRDATAS,
    output logic [USER_W-1:0]             HRUSERS,
    output logic [15:0]                   err_count
);

    localparam int              PW       = $clog2(NUM_PORTS + 1);
    localparam logic [PW-1:0]   DEF_PORT = PW'(NUM_PORTS);
    localparam logic [PW-1:0]   RMP_PORT = PW'(REMAP_PORT);

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_e;

    ds_state_e       ds_state_q, ds_state_d;
    logic [PW-1:0]   data_out_port_q, data_out_port_d;
    logic [PW-1:0]   match_port;
    logic [PW-1:0]   addr_out_port;
    logic            ds_qual;
    logic            ds_ready;
    logic [1:0]      ds_resp;

    // Lowest index wins on overlap, so scan downwards; remap overrides all.
    always_comb begin
        match_port = DEF_PORT;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (decode_addr_dec >= ADDR_BASE[i*22 +: 22] &&
                decode_addr_dec <= ADDR_LIMIT[i*22 +: 22]) begin
                match_port = PW'(i);
            end
        end
        if (remapping_dec && decode_addr_dec <= REMAP_LIMIT) begin
            match_port = RMP_PORT;
        end
    end

    always_comb begin
        addr_out_port = match_port;
        if (trans_dec == 2'b00 && data_out_port_q < DEF_PORT) begin
            addr_out_port = data_out_port_q;
        end
    end

    always_comb begin
        sel_out    = '0;
        active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_out_port == PW'(i)) begin
                sel_out[i] = sel_dec;
                active_dec = active_in[i];
            end
        end
    end

    assign data_out_port_d = HREADYS ? addr_out_port : data_out_port_q;

    assign ds_qual = sel_dec && HREADYS && trans_dec[1] &&
                     (addr_out_port == DEF_PORT);

    always_comb begin
        ds_state_d = ds_state_q;
        ds_ready   = 1'b1;
        ds_resp    = 2'b00;
        unique case (ds_state_q)
            DS_IDLE: begin
                if (ds_qual) ds_state_d = DS_ERR1;
            end
            DS_ERR1: begin
                ds_ready   = 1'b0;
                ds_resp    = 2'b01;
                ds_state_d = DS_ERR2;
            end
            DS_ERR2: begin
                ds_resp    = 2'b01;
                ds_state_d = ds_qual ? DS_ERR1 : DS_IDLE;
            end
            default: ds_state_d = DS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ds_state_q      <= DS_IDLE;
            data_out_port_q <= '0;
        end else begin
            ds_state_q      <= ds_state_d;
            data_out_port_q <= data_out_port_d;
        end
    end

    always_comb begin
        HREADYOUTS = ds_ready;
        HRESPS     = ds_resp;
        HRDATAS    = '0;
        HRUSERS    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_out_port_q == PW'(i)) begin
                HREADYOUTS = readyout_in[i];
                HRESPS     = resp_in[2*i +: 2];
                HRDATAS    = rdata_in[i*DATA_W +: DATA_W];
                HRUSERS    = ruser_in[i*USER_W +: USER_W];
            end
        end
    end

`ifdef AHB_DEC_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Count each new ERROR response start, not the second beat.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (ds_state_d == DS_ERR1 && ds_state_q != DS_ERR1 &&
            err_cnt_q != 16'hffff) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ahb_param_decoder.sv
// Scoreboard bench for ahb_param_decoder: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_ahb_param_decoder;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NS   = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;

    localparam int K_SEL = 0;
    localparam int K_RSP = 1;
    localparam int K_RD  = 2;
    localparam int K_RU  = 3;
    localparam int K_ACT = 4;
    localparam int K_ERR = 5;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          remapping_dec;
    logic          HREADYS;
    logic          sel_dec;
    logic [21:0]   decode_addr_dec;
    logic [1:0]    trans_dec;
    logic [3:0]    active_in;
    logic [3:0]    readyout_in;
    logic [7:0]    resp_in;
    logic [127:0]  rdata_in;
    logic [127:0]  ruser_in;
    logic [3:0]    sel_out;
    logic          active_dec;
    logic          HREADYOUTS;
    logic [1:0]    HRESPS;
    logic [31:0]   HRDATAS;
    logic [31:0]   HRUSERS;
    logic [15:0]   err_count;

    ahb_param_decoder dut (
        .HCLK            (HCLK),
        .HRESET          (HRESET),
        .remapping_dec   (remapping_dec),
        .HREADYS         (HREADYS),
        .sel_dec         (sel_dec),
        .decode_addr_dec (decode_addr_dec),
        .trans_dec       (trans_dec),
        .active_in       (active_in),
        .readyout_in     (readyout_in),
        .resp_in         (resp_in),
        .rdata_in        (rdata_in),
        .ruser_in        (ruser_in),
        .sel_out         (sel_out),
        .active_dec      (active_dec),
        .HREADYOUTS      (HREADYOUTS),
        .HRESPS          (HRESPS),
        .HRDATAS         (HRDATAS),
        .HRUSERS         (HRUSERS),
        .err_count       (err_count)
    );

    initial forever #5 HCLK = ~HCLK;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] v;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic logic [31:0] ecnt(input int n);
`ifdef AHB_DEC_ERRCNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic step(input bit rst, input bit s, input logic [21:0] a,
                        input logic [1:0] t, input bit r, input bit rm);
        @(posedge HCLK);
        #1;
        HRESET          = rst;
        sel_dec         = s;
        decode_addr_dec = a;
        trans_dec       = t;
        HREADYS         = r;
        remapping_dec   = rm;
    endtask

    task automatic chk(input int k, input logic [31:0] v, input string nm,
                       input int d = 0);
        q.push_back('{cyc + d, k, v, nm});
    endtask

    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge HCLK);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                case (e.kind)
                    K_SEL:   act = {28'd0, sel_out};
                    K_RSP:   act = {29'd0, HREADYOUTS, HRESPS};
                    K_RD:    act = HRDATAS;
                    K_RU:    act = HRUSERS;
                    K_ACT:   act = {31'd0, active_dec};
                    default: act = {16'd0, err_count};
                endcase
                total++;
                if (e.cyc != cyc || act !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h want=%h",
                             e.nm, cyc, act, e.v);
                end
            end
        end
    end

    initial begin
        // port p: rdata A000000p, ruser B000000p
        // {ready,resp}: p0=010 p1=111 p2=011 p3=100; active p0..p3=1,0,0,1
        rdata_in    = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
        ruser_in    = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
        readyout_in = 4'b1010;
        resp_in     = {2'b00, 2'b11, 2'b11, 2'b10};
        active_in   = 4'b1001;
        HRESET = 1'b1; sel_dec = 1'b0; decode_addr_dec = '0;
        trans_dec = IDLE; HREADYS = 1'b1; remapping_dec = 1'b0;

        step(1, 0, 22'h0, IDLE, 1, 0);
        step(1, 0, 22'h0, IDLE, 1, 0);
        step(0, 0, 22'h0, IDLE, 1, 0);
        chk(K_RSP, 32'h2, "rst_rsp");
        chk(K_RD, 32'hA0000000, "rst_rdata");
        chk(K_ERR, 32'h0, "rst_err");
        chk(K_SEL, 32'h0, "rst_sel");

        step(0, 1, 22'h000150, NS, 1, 0);
        chk(K_SEL, 32'h2, "dec_p1");
        chk(K_ACT, 32'h0, "act_p1");
        chk(K_RD, 32'hA0000001, "p1_rdata", 1);
        chk(K_RU, 32'hB0000001, "p1_ruser", 1);
        chk(K_RSP, 32'h7, "p1_rsp", 1);
        step(0, 0, 22'h0, IDLE, 1, 0);

        step(0, 1, 22'h000010, NS, 1, 1);
        chk(K_SEL, 32'h2, "remap_on");
        step(0, 1, 22'h000010, NS, 1, 0);
        chk(K_SEL, 32'h1, "remap_off");
        chk(K_RD, 32'hA0000001, "remap_data");
        chk(K_RD, 32'hA0000000, "p0_data", 1);

        step(0, 1, 22'h0002ab, NS, 1, 0);
        chk(K_SEL, 32'h4, "dec_p2");
        step(0, 1, 22'h3fffff, IDLE, 1, 0);
        chk(K_SEL, 32'h4, "hold_sel");
        chk(K_ACT, 32'h0, "hold_act");
        chk(K_RD, 32'hA0000002, "p2_data");
        chk(K_RD, 32'hA0000002, "hold_data", 1);

        step(0, 1, 22'h3fffff, NS, 1, 0);
        chk(K_SEL, 32'h0, "unmap_sel");
        chk(K_ACT, 32'h1, "unmap_act");
        chk(K_RSP, 32'h1, "err1", 1);
        chk(K_RD, 32'h0, "ds_rdata", 1);
        chk(K_RU, 32'h0, "ds_ruser", 1);
        chk(K_ERR, ecnt(1), "err_cnt1", 1);
        chk(K_RSP, 32'h5, "err2", 2);
        step(0, 1, 22'h3fffff, NS, 0, 0);
        step(0, 0, 22'h0, IDLE, 1, 0);
        chk(K_RSP, 32'h2, "back_p0", 1);
        step(0, 0, 22'h0, IDLE, 1, 0);

        step(0, 1, 22'h3fffff, NS, 1, 0);
        chk(K_RSP, 32'h1, "chain_e1a", 1);
        chk(K_ERR, ecnt(2), "chain_cnt2", 1);
        chk(K_RSP, 32'h5, "chain_e2a", 2);
        chk(K_RSP, 32'h1, "chain_e1b", 3);
        chk(K_ERR, ecnt(3), "chain_cnt3", 3);
        chk(K_RSP, 32'h5, "chain_e2b", 4);
        step(0, 1, 22'h3fffff, NS, 0, 0);
        step(0, 1, 22'h3fffff, SEQ, 1, 0);
        step(0, 0, 22'h0, IDLE, 0, 0);
        step(0, 0, 22'h000200, IDLE, 1, 0);
        chk(K_RSP, 32'h3, "chain_p2", 1);

        step(0, 1, 22'h3fffff, BUSY, 1, 0);
        chk(K_RSP, 32'h4, "busy_okay", 1);
        chk(K_RD, 32'h0, "busy_rdata", 1);
        step(0, 1, 22'h3fffff, NS, 1, 0);
        chk(K_RSP, 32'h1, "pre_rst_e1", 1);
        chk(K_ERR, ecnt(4), "cnt4", 1);
        step(1, 0, 22'h0, IDLE, 0, 0);
        step(0, 0, 22'h0, IDLE, 1, 0);
        chk(K_RSP, 32'h2, "rst_abort");
        chk(K_RD, 32'hA0000000, "rst_abort_rd");
        chk(K_ERR, 32'h0, "rst_cnt");

        step(0, 1, 22'h0000ff, NS, 1, 0);
        chk(K_SEL, 32'h1, "edge_p0_hi");
        step(0, 1, 22'h000100, NS, 1, 0);
        chk(K_SEL, 32'h2, "edge_p1_lo");
        step(0, 1, 22'h0003ff, NS, 1, 0);
        chk(K_SEL, 32'h8, "edge_p3_hi");
        chk(K_ACT, 32'h1, "act_p3");
        step(0, 1, 22'h000400, NS, 1, 0);
        chk(K_SEL, 32'h0, "edge_unmap");
        chk(K_RSP, 32'h1, "edge_e1", 1);
        chk(K_ERR, ecnt(1), "edge_cnt", 1);
        chk(K_RSP, 32'h5, "edge_e2", 2);
        step(0, 1, 22'h000400, NS, 0, 0);
        step(0, 0, 22'h0, IDLE, 1, 0);

        step(0, 1, 22'h00001f, NS, 1, 1);
        chk(K_SEL, 32'h2, "remap_hi");
        step(0, 1, 22'h000020, NS, 1, 1);
        chk(K_SEL, 32'h1, "remap_out");
        step(0, 0, 22'h0, IDLE, 1, 0);

        repeat (3) @(posedge HCLK);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
